uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_rx_param.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, receiver FSM encoding and
// the elaboration-time sample-tick divider calculation.
package uart_pkg;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityEven = 1;
    localparam int unsigned ParityOdd  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } rxState_t;

    // round(clkFreq / (baud * overSample)), never below 1
    function automatic int unsigned calcDiv(input int unsigned clkFreq,
                                            input int unsigned baud,
                                            input int unsigned overSample);
        longint unsigned den;
        longint unsigned q;
        den = 64'(baud) * 64'(overSample);
        q   = (64'(clkFreq) + den / 2) / den;
        if (q < 1) begin
            q = 1;
        end
        return q[31:0];
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase
// restartable so the first tick lands DIV clocks after clear.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned Div  = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CntMax) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CntW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: majority-voted oversampling, optional parity,
// 1 or 2 stop bits, valid/ready output holding with overrun and framing flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 25000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] TickS0   = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE / 2);
    localparam logic [TickW-1:0] TickS2   = TickW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]       BitLast  = 4'(DATA_BITS - 1);
    localparam logic             StopLast = 1'(STOP_BITS - 1);

    logic                 rxMeta;
    logic                 rxSync;
    logic                 rxPrev;
    logic                 fallEdge;
    logic                 tick;
    logic                 tickClear;
    rxState_t             state;
    logic [TickW-1:0]     tickCnt;
    logic [TickW-1:0]     tickNext;
    logic [3:0]           bitCnt;
    logic                 stopCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parAcc;
    logic                 parErrFrame;
    logic                 samp0;
    logic                 samp1;
    logic                 bitVal;
    logic                 decide;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    assign fallEdge  = rxPrev & ~rxSync;
    assign tickClear = (state == StIdle) && fallEdge;
    assign tickNext  = (tickCnt == TickLast) ? '0 : tickCnt + TickW'(1);
    assign decide    = tick && (tickCnt == TickS2);
    assign bitVal    = (samp0 & samp1) | (samp0 & rxSync) | (samp1 & rxSync);
    assign busy      = (state != StIdle);

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(tickClear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            tickCnt     <= '0;
            bitCnt      <= '0;
            stopCnt     <= 1'b0;
            shiftReg    <= '0;
            parAcc      <= 1'b0;
            parErrFrame <= 1'b0;
            samp0       <= 1'b1;
            samp1       <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (tick && (tickCnt == TickS0)) samp0 <= rxSync;
            if (tick && (tickCnt == TickS1)) samp1 <= rxSync;
            // Tick phase runs continuously through a frame; states change at mid-bit.
            if (tick && (state inside {StStart, StData, StParity, StStop})) begin
                tickCnt <= tickNext;
            end

            unique case (state)
                StIdle: begin
                    if (fallEdge) begin
                        state   <= StStart;
                        tickCnt <= '0;
                    end
                end
                StStart: begin
                    if (decide) begin
                        if (bitVal) begin
                            state <= StIdle;
                        end else begin
                            state  <= StData;
                            bitCnt <= '0;
                            parAcc <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (decide) begin
                        shiftReg <= {bitVal, shiftReg[DATA_BITS-1:1]};
                        parAcc   <= parAcc ^ bitVal;
                        if (bitCnt == BitLast) begin
                            state       <= (PARITY_MODE != ParityNone) ? StParity : StStop;
                            stopCnt     <= 1'b0;
                            parErrFrame <= 1'b0;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (decide) begin
                        parErrFrame <= (PARITY_MODE == ParityEven) ? (parAcc ^ bitVal) :
                                       (PARITY_MODE == ParityOdd)  ? ~(parAcc ^ bitVal) : 1'b0;
                        state       <= StStop;
                    end
                end
                StStop: begin
                    if (decide) begin
                        if (!bitVal) begin
                            frame_err <= 1'b1;
                            state     <= StBreakWait;
                            tickCnt   <= '0;
                        end else if (stopCnt == StopLast) begin
                            state <= StIdle;
                            // A held word survives unless it is being accepted this cycle.
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= shiftReg;
                                parity_err <= parErrFrame;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            stopCnt <= 1'b1;
                        end
                    end
                end
                StBreakWait: begin
                    if (!rxSync) begin
                        tickCnt <= '0;
                    end else if (tick) begin
                        if (tickCnt == TickLast) begin
                            state <= StIdle;
                        end else begin
                            tickCnt <= tickNext;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: 8N1 and 7E1 instances at DIV=10,
// scoreboard of expected words popped as the receivers deliver them.
module tb_uart_rx_param;

    localparam int unsigned ClkFreq = 18432000;
    localparam int unsigned Baud    = 115200;
    localparam int unsigned Os      = 16;
    localparam int          BitClks = 160;

    typedef struct {
        logic [8:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxdA;
    logic       rxdB;
    logic       rx_readyA;
    logic       rx_readyB;
    logic [7:0] rx_dataA;
    logic [6:0] rx_dataB;
    logic       rx_validA, rx_validB;
    logic       parity_errA, parity_errB;
    logic       frame_errA, frame_errB;
    logic       overrun_errA, overrun_errB;
    logic       busyA, busyB;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   feCntA  = 0;
    int   ovCntA  = 0;
    int   vCntA   = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(ClkFreq), .BAUD(Baud), .OVERSAMPLE(Os),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
    ) dutA (
        .clk(clk), .rst(rst), .rxd(rxdA), .rx_data(rx_dataA), .rx_valid(rx_validA),
        .rx_ready(rx_readyA), .parity_err(parity_errA), .frame_err(frame_errA),
        .overrun_err(overrun_errA), .busy(busyA)
    );

    uart_rx_param #(
        .CLK_FREQ(ClkFreq), .BAUD(Baud), .OVERSAMPLE(Os),
        .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)
    ) dutB (
        .clk(clk), .rst(rst), .rxd(rxdB), .rx_data(rx_dataB), .rx_valid(rx_validB),
        .rx_ready(rx_readyB), .parity_err(parity_errB), .frame_err(frame_errB),
        .overrun_err(overrun_errB), .busy(busyB)
    );

    always @(negedge clk) begin
        if (frame_errA === 1'b1) feCntA++;
        if (overrun_errA === 1'b1) ovCntA++;
        if (rx_validA === 1'b1) vCntA++;
    end

    function automatic logic validOf(input int sel);
        return (sel == 0) ? rx_validA : rx_validB;
    endfunction

    task automatic driveLine(input int sel, input logic v);
        if (sel == 0) rxdA = v;
        else rxdB = v;
        repeat (BitClks) @(negedge clk);
    endtask

    // A low stop bit leaves the line low afterwards (break condition).
    task automatic sendFrame(input int sel, input logic [8:0] data, input int nData,
                             input bit usePar, input logic parBit, input logic stopVal);
        driveLine(sel, 1'b0);
        for (int i = 0; i < nData; i++) driveLine(sel, data[i]);
        if (usePar) driveLine(sel, parBit);
        driveLine(sel, stopVal);
    endtask

    task automatic waitValid(input int sel, input int maxCyc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= maxCyc; c++) begin
            @(negedge clk);
            if (validOf(sel) === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rxdA = 1'b1; rxdB = 1'b1; rx_readyA = 1'b1; rx_readyB = 1'b1;
        repeat (4) @(negedge clk);
        nChecks++;
        if ({rx_dataA, rx_validA, parity_errA, frame_errA, overrun_errA, busyA} !== 13'd0) begin
            nFails++;
            $display("FAIL reset_A: outputs %b want all zero",
                     {rx_dataA, rx_validA, parity_errA, frame_errA, overrun_errA, busyA});
        end
        nChecks++;
        if ({rx_dataB, rx_validB, parity_errB, frame_errB, overrun_errB, busyB} !== 12'd0) begin
            nFails++;
            $display("FAIL reset_B: outputs %b want all zero",
                     {rx_dataB, rx_validB, parity_errB, frame_errB, overrun_errB, busyB});
        end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        nChecks++;
        if (busyA !== 1'b0 || rx_validA !== 1'b0) begin
            nFails++;
            $display("FAIL reset_idle: busy %b valid %b want 0 0", busyA, rx_validA);
        end
    endtask

    task automatic test_basic();
        int   cyc;
        int   fe0;
        int   ov0;
        int   midStop;
        exp_t e;
        fe0 = feCntA; ov0 = ovCntA;
        midStop = BitClks * 9 + BitClks / 2;
        rx_readyA = 1'b1;
        expQ.push_back('{data: 9'h0A5, par: 1'b0});
        fork
            sendFrame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
            begin
                waitValid(0, 1800, cyc);
                nChecks++;
                if (cyc < midStop || cyc > midStop + 40) begin
                    nFails++;
                    $display("FAIL basic_latency: valid after %0d clks want %0d..%0d",
                             cyc, midStop, midStop + 40);
                end
                if (cyc > 0) begin
                    e = expQ.pop_front();
                    nChecks++;
                    if (rx_dataA !== e.data[7:0]) begin
                        nFails++;
                        $display("FAIL basic_data: got %h want %h", rx_dataA, e.data[7:0]);
                    end
                    nChecks++;
                    if (parity_errA !== e.par) begin
                        nFails++;
                        $display("FAIL basic_parity: got %b want %b", parity_errA, e.par);
                    end
                    @(negedge clk);
                    nChecks++;
                    if (rx_validA !== 1'b0) begin
                        nFails++;
                        $display("FAIL basic_valid_width: valid %b one clk later want 0",
                                 rx_validA);
                    end
                end
            end
        join
        nChecks++;
        if (feCntA != fe0 || ovCntA != ov0) begin
            nFails++;
            $display("FAIL basic_flags: frame %0d overrun %0d pulses want 0 0",
                     feCntA - fe0, ovCntA - ov0);
        end
    endtask

    task automatic test_parity();
        logic [8:0] words[2];
        int         cyc;
        exp_t       e;
        words[0] = 9'h041;
        words[1] = 9'h043;
        rx_readyB = 1'b1;
        for (int w = 0; w < 2; w++) begin
            // Parity bit 1 in both: wrong for 0x41 (two ones), right for 0x43 (three ones).
            expQ.push_back('{data: words[w], par: (^words[w][6:0]) ^ 1'b1});
            fork
                sendFrame(1, words[w], 7, 1'b1, 1'b1, 1'b1);
                begin
                    waitValid(1, 1800, cyc);
                    nChecks++;
                    if (cyc < 0) begin
                        nFails++;
                        $display("FAIL parity_timeout: word %0d got no valid want valid", w);
                    end else begin
                        e = expQ.pop_front();
                        nChecks++;
                        if (rx_dataB !== e.data[6:0] || parity_errB !== e.par) begin
                            nFails++;
                            $display("FAIL parity_word%0d: data %h err %b want %h %b", w,
                                     rx_dataB, parity_errB, e.data[6:0], e.par);
                        end
                    end
                end
            join
        end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vCntA;
        rxdA = 1'b0;
        repeat (12) @(negedge clk);
        nChecks++;
        if (busyA !== 1'b1) begin
            nFails++;
            $display("FAIL glitch_start: busy %b want 1", busyA);
        end
        repeat (18) @(negedge clk);
        rxdA = 1'b1;
        repeat (200) @(negedge clk);
        nChecks++;
        if (busyA !== 1'b0 || vCntA != v0) begin
            nFails++;
            $display("FAIL glitch_reject: busy %b valid cycles %0d want 0 0", busyA, vCntA - v0);
        end
    endtask

    task automatic test_frame_err();
        int   fe0;
        int   v0;
        int   cyc;
        exp_t e;
        fe0 = feCntA; v0 = vCntA;
        rx_readyA = 1'b1;
        sendFrame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
        repeat (2 * BitClks) @(negedge clk);
        nChecks++;
        if (feCntA - fe0 != 1) begin
            nFails++;
            $display("FAIL frame_pulse: frame_err high %0d clks want 1", feCntA - fe0);
        end
        nChecks++;
        if (busyA !== 1'b1) begin
            nFails++;
            $display("FAIL frame_break_busy: busy %b want 1", busyA);
        end
        rxdA = 1'b1;
        repeat (BitClks / 2) @(negedge clk);
        rxdA = 1'b0;
        repeat (BitClks / 2) @(negedge clk);
        rxdA = 1'b1;
        repeat (BitClks / 4) @(negedge clk);
        nChecks++;
        if (busyA !== 1'b1) begin
            nFails++;
            $display("FAIL frame_short_high: busy %b want 1 (still in break wait)", busyA);
        end
        repeat (2 * BitClks) @(negedge clk);
        nChecks++;
        if (busyA !== 1'b0 || vCntA != v0) begin
            nFails++;
            $display("FAIL frame_recover: busy %b valid cycles %0d want 0 0", busyA, vCntA - v0);
        end
        expQ.push_back('{data: 9'h096, par: 1'b0});
        fork
            sendFrame(0, 9'h096, 8, 1'b0, 1'b0, 1'b1);
            begin
                waitValid(0, 1800, cyc);
                nChecks++;
                if (cyc < 0) begin
                    nFails++;
                    $display("FAIL frame_next_timeout: no valid want valid");
                end else begin
                    e = expQ.pop_front();
                    nChecks++;
                    if (rx_dataA !== e.data[7:0]) begin
                        nFails++;
                        $display("FAIL frame_next_data: got %h want %h", rx_dataA, e.data[7:0]);
                    end
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        int   ov0;
        int   cyc;
        int   gap;
        exp_t e;
        ov0 = ovCntA;
        rx_readyA = 1'b0;
        expQ.push_back('{data: 9'h011, par: 1'b0});
        fork
            begin
                sendFrame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
                sendFrame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
            end
            begin
                waitValid(0, 1800, cyc);
                nChecks++;
                if (cyc < 0) begin
                    nFails++;
                    $display("FAIL b2b_first_timeout: no valid want valid");
                end else begin
                    e = expQ.pop_front();
                    nChecks++;
                    if (rx_dataA !== e.data[7:0]) begin
                        nFails++;
                        $display("FAIL b2b_first_data: got %h want %h", rx_dataA, e.data[7:0]);
                    end
                    gap = -1;
                    for (int c = 1; c <= 1800; c++) begin
                        @(negedge clk);
                        if (overrun_errA === 1'b1) begin
                            gap = c;
                            break;
                        end
                    end
                    // Second frame ends exactly one frame time after the first.
                    nChecks++;
                    if (gap < 10 * BitClks - 20 || gap > 10 * BitClks + 20) begin
                        nFails++;
                        $display("FAIL b2b_overrun_time: overrun %0d clks after first valid want %0d+-20",
                                 gap, 10 * BitClks);
                    end
                    nChecks++;
                    if (rx_dataA !== 8'h11 || rx_validA !== 1'b1) begin
                        nFails++;
                        $display("FAIL b2b_keep_old: data %h valid %b want 11 1", rx_dataA, rx_validA);
                    end
                end
            end
        join
        nChecks++;
        if (ovCntA - ov0 != 1) begin
            nFails++;
            $display("FAIL b2b_overrun_pulse: overrun high %0d clks want 1", ovCntA - ov0);
        end
        rx_readyA = 1'b1;
        @(negedge clk);
        nChecks++;
        if (rx_validA !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_accept: valid %b after accept want 0", rx_validA);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        exp_t e;
        rx_readyA = 1'b0;
        expQ.push_back('{data: 9'h00F, par: 1'b0});
        fork
            sendFrame(0, 9'h00F, 8, 1'b0, 1'b0, 1'b1);
            begin
                waitValid(0, 1800, cyc);
                nChecks++;
                if (cyc < 0) begin
                    nFails++;
                    $display("FAIL rstmid_prime_timeout: no valid want valid");
                end else begin
                    e = expQ.pop_front();
                    nChecks++;
                    if (rx_dataA !== e.data[7:0]) begin
                        nFails++;
                        $display("FAIL rstmid_prime_data: got %h want %h", rx_dataA, e.data[7:0]);
                    end
                end
            end
        join
        // Reset lands in a low data bit and releases in the high run, so no edge follows.
        fork
            sendFrame(0, 9'h0F0, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 * BitClks + BitClks / 2) @(negedge clk);
                nChecks++;
                if (busyA !== 1'b1 || rx_validA !== 1'b1) begin
                    nFails++;
                    $display("FAIL rstmid_before: busy %b valid %b want 1 1", busyA, rx_validA);
                end
                rst = 1'b0;
                @(negedge clk);
                nChecks++;
                if ({rx_dataA, rx_validA, parity_errA, frame_errA, overrun_errA, busyA} !== 13'd0) begin
                    nFails++;
                    $display("FAIL rstmid_clear: outputs %b want all zero",
                             {rx_dataA, rx_validA, parity_errA, frame_errA, overrun_errA, busyA});
                end
                repeat (2 * BitClks) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (BitClks) @(negedge clk);
        nChecks++;
        if (busyA !== 1'b0 || rx_validA !== 1'b0) begin
            nFails++;
            $display("FAIL rstmid_partial: busy %b valid %b want 0 0", busyA, rx_validA);
        end
        rx_readyA = 1'b1;
        expQ.push_back('{data: 9'h05A, par: 1'b0});
        fork
            sendFrame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
            begin
                waitValid(0, 1800, cyc);
                nChecks++;
                if (cyc < 0) begin
                    nFails++;
                    $display("FAIL rstmid_next_timeout: no valid want valid");
                end else begin
                    e = expQ.pop_front();
                    nChecks++;
                    if (rx_dataA !== e.data[7:0]) begin
                        nFails++;
                        $display("FAIL rstmid_next_data: got %h want %h", rx_dataA, e.data[7:0]);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_drain: %0d words left want 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
